prog_rom_loadable: RTL and testbench
====================================

// Module: prog_rom_loadable
// PURPOSE
//   Parametrised, run-time loadable instruction memory for the MiniALU core.
//   Replaces the hard-coded case-ROM with a synchronous-read RAM. An external
//   loader (UART/testbench) fills the RAM through a valid/ready port before
//   execution starts. Sits between the program counter (fetch side) and the
//   loader (write side).
// PARAMETERS
//   ADDR_WIDTH    16          width of iAddress and iLoadCount
//   DATA_WIDTH    28          instruction width
//   DEPTH         64          number of stored words; must be <= 2**ADDR_WIDTH
//   DEFAULT_WORD  28'h00000AA word returned for addresses >= loaded length
//                             (top level overrides this with {`LED,24'hAA})
// PORTS
//   Clock         in   1           rising-edge clock
//   Reset         in   1           asynchronous, active-low reset
//   iFetch        in   1           fetch request for iAddress
//   iAddress      in   ADDR_WIDTH  fetch address
//   oInstruction  out  DATA_WIDTH  fetched word
//   oValid        out  1           oInstruction holds a fresh fetch result
//   iLoadStart    in   1           1-cycle pulse: begin a load of iLoadCount words
//   iLoadCount    in   ADDR_WIDTH  number of words to load; sampled on iLoadStart
//   iLoadData     in   DATA_WIDTH  word to write
//   iLoadValid    in   1           iLoadData is valid
//   oLoadReady    out  1           block accepts a load word this cycle
//   oLoadDone     out  1           1-cycle pulse after the last word is written
//   oBusy         out  1           high while in LOADING
// BEHAVIOUR
//   Reset (Reset=0, async): state=EMPTY, length=0, wptr=0, oInstruction=0,
//     oValid=0, oLoadReady=0, oLoadDone=0, oBusy=0. RAM contents are not reset.
//   FSM: EMPTY, LOADING, READY.
//     EMPTY   -> LOADING on iLoadStart with a count != 0.
//     LOADING -> READY on the accepted write where wptr == count-1.
//     READY   -> LOADING on iLoadStart with a count != 0 (reload).
//   Load start: count = min(iLoadCount, DEPTH). length := 0 and wptr := 0.
//     A count of 0 is ignored (state is unchanged).
//     iLoadStart while in LOADING is ignored.
//   LOADING state:
//     - oLoadReady=1 and oBusy=1.
//     - A word is accepted when iLoadValid && oLoadReady: mem[wptr] <= iLoadData,
//       then wptr++.
//     - On the last word: length := count, oLoadDone=1 in the next cycle,
//       oLoadReady drops in that same next cycle.
//   Fetch (latency 1):
//     - iFetch sampled in cycle N while state==READY: in N+1, oValid=1 and
//       oInstruction = (iAddress < length) ? mem[iAddress] : DEFAULT_WORD.
//     - iFetch=0, or state != READY: oValid=0 in N+1 and oInstruction holds
//       its last value.
//     - Back-to-back fetches give one result per cycle.
//   Simultaneous events:
//     - Final load write and iFetch in the same cycle: the fetch sees the
//       pre-edge state (LOADING), so oValid=0.
//     - iFetch in the cycle of a reload start: serviced with the old program.
//   Reset mid-load: returns to EMPTY; the partially written RAM is unusable
//     (length=0) until a complete load finishes.
//   Width rules: wptr and length are ADDR_WIDTH bits. The address compare is
//     unsigned. No wrap: wptr never exceeds count-1.
// TESTING
//   1. Reset, then iFetch addr 0 -> oValid stays 0 and oInstruction=0;
//      oBusy=0.
//   2. Start count=3, write 28'h1000001/2/3 with iLoadValid held high ->
//      oLoadDone pulses one cycle after the 3rd write; fetches of 0,1,2 then
//      return 1000001/2/3 one cycle later each, oValid=1.
//   3. After test 2, fetch addr 3 and addr 63 -> DEFAULT_WORD with oValid=1.
//   4. Start count=100 with DEPTH=64 -> exactly 64 words accepted; fetch 63
//      returns the last word; iLoadValid gaps stall wptr with no writes.
//   5. Assert Reset after 2 of 5 words, then release -> state EMPTY,
//      oLoadReady=0, fetches give oValid=0.
//   6. iLoadStart in LOADING and a count=0 start in READY -> both ignored;
//      the program and length are unchanged.

Source files
------------

// File: rtl/prog_rom_loadable.sv
// Run-time loadable instruction memory: a loader fills the RAM through a
// valid/ready port, then the fetch side reads it with one cycle of latency.
module prog_rom_loadable #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 28,
    parameter int DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = 'h00000AA
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iFetch,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oValid,
    input  logic                  iLoadStart,
    input  logic [ADDR_WIDTH-1:0] iLoadCount,
    input  logic [DATA_WIDTH-1:0] iLoadData,
    input  logic                  iLoadValid,
    output logic                  oLoadReady,
    output logic                  oLoadDone,
    output logic                  oBusy,
    output logic [1:0]            dbg_state
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] count;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] length;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Load handshake: a word transfers on any rising edge where iLoadValid and
    // oLoadReady are both high; oLoadReady is high exactly while in LOADING.
    logic write_en;
    assign write_en   = (state == LOADING) && iLoadValid;
    assign oLoadReady = (state == LOADING);
    assign oBusy      = (state == LOADING);
    assign dbg_state  = state;

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge Clock) begin
        if (write_en) begin
            mem[wptr[IDX_W-1:0]] <= iLoadData;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= EMPTY;
            count        <= '0;
            wptr         <= '0;
            length       <= '0;
            oInstruction <= '0;
            oValid       <= 1'b0;
            oLoadDone    <= 1'b0;
        end else begin
            oValid    <= 1'b0;
            oLoadDone <= 1'b0;

            // Fetch uses pre-edge state and length, so a reload start in the
            // same cycle is still served from the old program.
            if (iFetch && state == READY) begin
                oValid       <= 1'b1;
                oInstruction <= (iAddress < length) ? mem[iAddress[IDX_W-1:0]]
                                                    : DEFAULT_WORD;
            end

            case (state)
                EMPTY, READY: begin
                    if (iLoadStart && iLoadCount != '0) begin
                        count  <= (iLoadCount > DEPTH_W) ? DEPTH_W : iLoadCount;
                        length <= '0;
                        wptr   <= '0;
                        state  <= LOADING;
                    end
                end
                LOADING: begin
                    if (iLoadValid) begin
                        if (wptr == count - ONE) begin
                            length    <= count;
                            oLoadDone <= 1'b1;
                            state     <= READY;
                        end else begin
                            wptr <= wptr + ONE;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_rom_loadable.sv
// Directed bench for prog_rom_loadable: load, fetch, clamp, reset and
// ignored-start scenarios with hand-computed expected words.
module tb_prog_rom_loadable;

    localparam logic [27:0] DEF = 28'h00000AA;
    localparam logic [1:0]  ST_EMPTY = 2'd0;
    localparam logic [1:0]  ST_LOADING = 2'd1;
    localparam logic [1:0]  ST_READY = 2'd2;

    logic        Clock;
    logic        Reset;
    logic        iFetch;
    logic [15:0] iAddress;
    logic [27:0] oInstruction;
    logic        oValid;
    logic        iLoadStart;
    logic [15:0] iLoadCount;
    logic [27:0] iLoadData;
    logic        iLoadValid;
    logic        oLoadReady;
    logic        oLoadDone;
    logic        oBusy;
    logic [1:0]  dbg_state;

    int vectors;
    int miscompares;

    prog_rom_loadable dut (
        .Clock(Clock), .Reset(Reset),
        .iFetch(iFetch), .iAddress(iAddress),
        .oInstruction(oInstruction), .oValid(oValid),
        .iLoadStart(iLoadStart), .iLoadCount(iLoadCount),
        .iLoadData(iLoadData), .iLoadValid(iLoadValid),
        .oLoadReady(oLoadReady), .oLoadDone(oLoadDone),
        .oBusy(oBusy), .dbg_state(dbg_state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic start_load(input logic [15:0] cnt);
        iLoadStart = 1'b1;
        iLoadCount = cnt;
        tick();
        iLoadStart = 1'b0;
        iLoadCount = '0;
    endtask

    task automatic write_word(input logic [27:0] data);
        iLoadValid = 1'b1;
        iLoadData  = data;
        tick();
        iLoadValid = 1'b0;
        iLoadData  = '0;
    endtask

    task automatic do_fetch(input logic [15:0] addr, output logic v, output logic [27:0] d);
        iFetch   = 1'b1;
        iAddress = addr;
        tick();
        iFetch   = 1'b0;
        v        = oValid;
        d        = oInstruction;
    endtask

    task automatic test_reset;
        logic v;
        logic [27:0] d;
        Reset = 1'b0;
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        vectors++;
        if (dbg_state !== ST_EMPTY || oBusy !== 1'b0 || oLoadReady !== 1'b0 || oLoadDone !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: state=%0d busy=%b ready=%b done=%b, want 0/0/0/0",
                     dbg_state, oBusy, oLoadReady, oLoadDone);
        end
        do_fetch(16'd0, v, d);
        vectors++;
        if (v !== 1'b0 || d !== 28'h0 || oBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fetch: valid=%b instr=%h busy=%b, want 0/0000000/0", v, d, oBusy);
        end
    endtask

    task automatic test_load_fetch;
        logic v;
        logic [27:0] d;
        start_load(16'd3);
        vectors++;
        if (oLoadReady !== 1'b1 || oBusy !== 1'b1 || dbg_state !== ST_LOADING) begin
            miscompares++;
            $display("FAIL load_enter: ready=%b busy=%b state=%0d, want 1/1/1", oLoadReady, oBusy, dbg_state);
        end
        for (int i = 1; i <= 3; i++) begin
            iLoadValid = 1'b1;
            iLoadData  = 28'h1000000 + 28'(i);
            tick();
            vectors++;
            if (oLoadDone !== (i == 3) || oLoadReady !== (i != 3)) begin
                miscompares++;
                $display("FAIL load_word%0d: done=%b ready=%b, want %b/%b", i, oLoadDone, oLoadReady,
                         (i == 3), (i != 3));
            end
        end
        iLoadValid = 1'b0;
        tick();
        vectors++;
        if (oLoadDone !== 1'b0 || dbg_state !== ST_READY || oBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b state=%0d busy=%b, want 0/2/0", oLoadDone, dbg_state, oBusy);
        end
        // back-to-back fetches, one result per cycle
        for (int a = 0; a < 3; a++) begin
            do_fetch(16'(a), v, d);
            vectors++;
            if (v !== 1'b1 || d !== 28'h1000001 + 28'(a)) begin
                miscompares++;
                $display("FAIL fetch_addr%0d: valid=%b instr=%h, want 1/%h", a, v, d, 28'h1000001 + 28'(a));
            end
        end
        tick();
        vectors++;
        if (oValid !== 1'b0 || oInstruction !== 28'h1000003) begin
            miscompares++;
            $display("FAIL idle_hold: valid=%b instr=%h, want 0/1000003", oValid, oInstruction);
        end
    endtask

    task automatic test_default_word;
        logic v;
        logic [27:0] d;
        do_fetch(16'd3, v, d);
        vectors++;
        if (v !== 1'b1 || d !== DEF) begin
            miscompares++;
            $display("FAIL default_addr3: valid=%b instr=%h, want 1/%h", v, d, DEF);
        end
        do_fetch(16'd63, v, d);
        vectors++;
        if (v !== 1'b1 || d !== DEF) begin
            miscompares++;
            $display("FAIL default_addr63: valid=%b instr=%h, want 1/%h", v, d, DEF);
        end
    endtask

    task automatic test_clamp_gaps;
        logic v;
        logic [27:0] d;
        int accepted;
        start_load(16'd100);
        accepted = 0;
        for (int i = 0; i < 64; i++) begin
            if (i % 4 == 3) begin
                iLoadValid = 1'b0;
                iLoadData  = 28'hFFFFFFF;
                tick();
            end
            iLoadValid = 1'b1;
            iLoadData  = 28'h2000000 + 28'(i);
            tick();
            accepted++;
            if (accepted == 63) begin
                vectors++;
                if (oLoadDone !== 1'b0 || oLoadReady !== 1'b1) begin
                    miscompares++;
                    $display("FAIL clamp_63: done=%b ready=%b, want 0/1", oLoadDone, oLoadReady);
                end
            end
        end
        iLoadValid = 1'b0;
        vectors++;
        if (oLoadDone !== 1'b1 || oLoadReady !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_64: done=%b ready=%b, want 1/0", oLoadDone, oLoadReady);
        end
        do_fetch(16'd63, v, d);
        vectors++;
        if (v !== 1'b1 || d !== 28'h200003F) begin
            miscompares++;
            $display("FAIL clamp_fetch63: valid=%b instr=%h, want 1/200003f", v, d);
        end
        do_fetch(16'd2, v, d);
        vectors++;
        if (v !== 1'b1 || d !== 28'h2000002) begin
            miscompares++;
            $display("FAIL gap_fetch2: valid=%b instr=%h, want 1/2000002", v, d);
        end
        do_fetch(16'd4, v, d);
        vectors++;
        if (v !== 1'b1 || d !== 28'h2000004) begin
            miscompares++;
            $display("FAIL gap_fetch4: valid=%b instr=%h, want 1/2000004", v, d);
        end
        do_fetch(16'd64, v, d);
        vectors++;
        if (v !== 1'b1 || d !== DEF) begin
            miscompares++;
            $display("FAIL clamp_fetch64: valid=%b instr=%h, want 1/%h", v, d, DEF);
        end
    endtask

    task automatic test_reset_mid_load;
        logic v;
        logic [27:0] d;
        start_load(16'd5);
        write_word(28'h5000000);
        write_word(28'h5000001);
        #2;
        Reset = 1'b0;
        #2;
        vectors++;
        if (dbg_state !== ST_EMPTY || oLoadReady !== 1'b0 || oBusy !== 1'b0 || oInstruction !== 28'h0) begin
            miscompares++;
            $display("FAIL midload_reset: state=%0d ready=%b busy=%b instr=%h, want 0/0/0/0",
                     dbg_state, oLoadReady, oBusy, oInstruction);
        end
        tick();
        Reset = 1'b1;
        tick();
        do_fetch(16'd0, v, d);
        vectors++;
        if (v !== 1'b0 || dbg_state !== ST_EMPTY || oLoadReady !== 1'b0) begin
            miscompares++;
            $display("FAIL midload_fetch: valid=%b state=%0d ready=%b, want 0/0/0", v, dbg_state, oLoadReady);
        end
    endtask

    task automatic test_ignored_starts;
        logic v;
        logic [27:0] d;
        start_load(16'd2);
        write_word(28'h3000001);
        start_load(16'd5);
        vectors++;
        if (dbg_state !== ST_LOADING || oLoadReady !== 1'b1) begin
            miscompares++;
            $display("FAIL start_in_loading: state=%0d ready=%b, want 1/1", dbg_state, oLoadReady);
        end
        // final write with a fetch in the same cycle: fetch sees LOADING
        iFetch   = 1'b1;
        iAddress = 16'd0;
        write_word(28'h3000002);
        iFetch   = 1'b0;
        vectors++;
        if (oLoadDone !== 1'b1 || oValid !== 1'b0) begin
            miscompares++;
            $display("FAIL final_write_fetch: done=%b valid=%b, want 1/0", oLoadDone, oValid);
        end
        start_load(16'd0);
        vectors++;
        if (dbg_state !== ST_READY || oBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_count: state=%0d busy=%b, want 2/0", dbg_state, oBusy);
        end
        do_fetch(16'd1, v, d);
        vectors++;
        if (v !== 1'b1 || d !== 28'h3000002) begin
            miscompares++;
            $display("FAIL keep_prog1: valid=%b instr=%h, want 1/3000002", v, d);
        end
        do_fetch(16'd2, v, d);
        vectors++;
        if (v !== 1'b1 || d !== DEF) begin
            miscompares++;
            $display("FAIL keep_len2: valid=%b instr=%h, want 1/%h", v, d, DEF);
        end
    endtask

    task automatic test_reload_fetch;
        logic v;
        logic [27:0] d;
        // reload start with a fetch in the same cycle: served from old program
        iFetch     = 1'b1;
        iAddress   = 16'd1;
        iLoadStart = 1'b1;
        iLoadCount = 16'd1;
        tick();
        iFetch     = 1'b0;
        iLoadStart = 1'b0;
        vectors++;
        if (oValid !== 1'b1 || oInstruction !== 28'h3000002 || dbg_state !== ST_LOADING) begin
            miscompares++;
            $display("FAIL reload_fetch: valid=%b instr=%h state=%0d, want 1/3000002/1",
                     oValid, oInstruction, dbg_state);
        end
        do_fetch(16'd0, v, d);
        vectors++;
        if (v !== 1'b0 || d !== 28'h3000002) begin
            miscompares++;
            $display("FAIL loading_fetch: valid=%b instr=%h, want 0/3000002", v, d);
        end
        write_word(28'h4000000);
        do_fetch(16'd0, v, d);
        vectors++;
        if (v !== 1'b1 || d !== 28'h4000000) begin
            miscompares++;
            $display("FAIL reload_word0: valid=%b instr=%h, want 1/4000000", v, d);
        end
        do_fetch(16'd1, v, d);
        vectors++;
        if (v !== 1'b1 || d !== DEF) begin
            miscompares++;
            $display("FAIL reload_len1: valid=%b instr=%h, want 1/%h", v, d, DEF);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset      = 1'b0;
        iFetch     = 1'b0;
        iAddress   = '0;
        iLoadStart = 1'b0;
        iLoadCount = '0;
        iLoadData  = '0;
        iLoadValid = 1'b0;
        test_reset();
        test_load_fetch();
        test_default_word();
        test_clamp_gaps();
        test_reset_mid_load();
        test_ignored_starts();
        test_reload_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
